// File: rtl/differentiator_pkg.sv
// Shared constants and parameter range checks for the differentiator / accumulator pair.
package differentiator_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int M_DEFAULT  = 1;
    localparam int DW_MIN     = 2;
    localparam int DW_MAX     = 64;
    localparam int M_MIN      = 1;
    localparam int M_MAX      = 16;

    function automatic bit dw_legal(input int dw);
        return (dw >= DW_MIN) && (dw <= DW_MAX);
    endfunction

    function automatic bit m_legal(input int m);
        return (m >= M_MIN) && (m <= M_MAX);
    endfunction

endpackage

// File: rtl/differentiator_diff_delay_line.sv
// M-deep sample history for the differentiator; tap presents x[n-M].
module diff_delay_line
    import differentiator_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int M  = M_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          shift_en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] tap
);

    logic [DW-1:0] hist [M];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) hist[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < M; i++) hist[i] <= '0;
        end else if (shift_en) begin
            hist[0] <= din;
            for (int i = 1; i < M; i++) hist[i] <= hist[i-1];
        end
    end

    assign tap = hist[M-1];

endmodule

// File: rtl/differentiator.sv
// Streaming differentiator y[n] = x[n] - x[n-M] (mod 2^DW) with a one-deep
// registered output stage and valid/ready handshakes on both sides.
module differentiator
    import differentiator_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int M  = M_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);

    if (!dw_legal(DW)) begin : g_bad_dw
        $error("differentiator: DW=%0d outside %0d..%0d", DW, DW_MIN, DW_MAX);
    end
    if (!m_legal(M)) begin : g_bad_m
        $error("differentiator: M=%0d outside %0d..%0d", M, M_MIN, M_MAX);
    end

    logic          in_hs;
    logic [DW-1:0] tap;
    logic [DW-1:0] diff;

    // rst_n gating keeps s_ready low throughout reset, not just after the first edge.
    assign s_ready = rst_n && !clr && (!m_valid || m_ready);
    assign in_hs   = s_valid && s_ready;
    assign diff    = s_data - tap;

    diff_delay_line #(
        .DW (DW),
        .M  (M)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .shift_en (in_hs),
        .din      (s_data),
        .tap      (tap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (clr) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (in_hs) begin
            m_valid <= 1'b1;
            m_data  <= diff;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
